bandai2003_mapper_gen2: RTL
===========================

Name: bandai2003_mapper_gen2

Overview:
Parametrised second-generation cartridge mapper for the Bandai 2003 bus, sitting between the console cartridge bus and the ROM/RAM chips.
- Runs fully synchronous to CLK: unlock FSM, boot-handshake shifter and bank registers are all clocked; bus strobes are sampled, not used as clocks.
- Generalised over gen1: variable bank-address width, split data buses with no internal tri-states, relock command, RAM write-protect, extended linear offset.

Parameters:
RADDR_W, 8, bank address output width; legal range 7..12.
SO_LEN, 18, boot bitstream length in bits.
SO_PAT, 18'h05140, boot bitstream, shifted out LSB first.
KEY0, 8'h5A, first unlock key address.
KEY1, 8'hA5, second unlock key address.

Ports:
CLK  in  1  system clock; all state updates on rising edge.
RST  in  1  synchronous reset, active-high.
CEn  in  1  cartridge chip enable, active-low.
WEn  in  1  write strobe, active-low.
OEn  in  1  read strobe, active-low.
SSn  in  1  0 = I/O port cycle, 1 = memory cycle.
ADDR  in  8  I/O cycle: port number. Memory cycle: [7:4] = segment A19..A16.
DQ_I  in  8  write data from bus.
DQ_O  out  8  read data to bus.
DQ_OE  out  1  external driver enable for DQ_O.
SO  out  1  boot handshake serial out.
LOCKED  out  1  1 while the unlock FSM is not in S_UNL.
ROMCEn  out  1  ROM chip enable, active-low.
RAMCEn  out  1  RAM chip enable, active-low.
RADDR  out  RADDR_W  bank address to ROM/RAM.

Behaviour:
Reset (RST=1 at a CLK edge):
- FSM -> S_K0; shifter all ones (SO=1).
- LAO, RAMB, ROMB0, ROMB1 = 8'hFF; LAOH = 4'h0; WP = 0; internal write-edge state cleared.
- Outputs after reset: LOCKED=1, DQ_OE=0, ROMCEn=1, RAMCEn=1, RADDR=0.
- RST asserted mid-operation behaves identically, including mid-shift and mid-write.

Unlock FSM, evaluated every CLK from ADDR:
- S_K0 -> S_K1 when ADDR==KEY0.
- S_K1 -> S_UNL when ADDR==KEY1; otherwise stays in S_K1 (lenient, gen1-compatible).
- S_UNL is absorbing; leave it only via RST or relock.
- On the S_K1->S_UNL edge, SO_PAT is loaded into the shifter. SO carries pattern bit 0 in the following cycle.
- In every other cycle the shifter shifts right and fills with 1. SO is high after SO_LEN cycles.

Writes (I/O cycle, unlocked only):
- Each cycle with WEn=0, register ADDR, DQ_I and io = (~SSn | ~CEn). Also register we_q = WEn.
- Commit in the cycle where WEn=1 and we_q=0, using the registered values. Latency: new value visible one CLK after the WEn rising edge is sampled.
- Writes while locked are discarded.

Register map:
- C0 LAO; C1 RAMB; C2 ROMB0; C3 ROMB1.
- CE LAOH: bits [3:0] are the high linear offset bits.
- CF CTRL: write bit0=1 -> relock (FSM -> S_K0; bank registers retained; shifter untouched). bit1 = WP.
- Reads of CF return {6'b0, WP, 1'b0}.
- Unmapped ports read 8'h00.

Reads:
- DQ_OE = ~LOCKED & io & ~OEn & WEn.
- DQ_O is combinational from the register map; 8'h00 when DQ_OE=0.

Memory decode:
- Memory cycle enable: mce = ~LOCKED & SSn & ~CEn.
- Segment 0: no chip enable asserted.
- Segment 1: RAMCEn=0, except forced high when WP=1 and WEn=0.
- Segments 2..15: ROMCEn=0.
- RADDR for segment 1 = RAMB; segment 2 = ROMB0; segment 3 = ROMB1. These are zero-extended or truncated to RADDR_W.
- RADDR for segments >=4 = {LAOH, LAO}[RADDR_W-5:0] concatenated with the segment number.
- RADDR = 0 when no chip enable is asserted.
- Decode outputs are combinational from current inputs and registers.

Simultaneous events:
- RST beats every other event.
- A relock commit and a KEY match in the same cycle: relock wins.
- A write commit to a bank register is visible to the memory decode from the next cycle.

Optional Feature:
BANDAI_GPIO_EN:
- Adds ports IO_I[3:0] in, IO_O[3:0] out, IO_OE[3:0] out.
- Port CC IOCTL: direction register, 1 = output.
- Port CD IOSCN: writes set the output latch.
- IO_OE = IOCTL; IO_O = IOSCN latch.
- IO_I passes through a 2-flop synchroniser.
- Reading CD returns per bit: IOCTL ? latch : synchronised input. Input pin change reaches reads 2 CLK later.
- IOCTL and the latch reset to 0.
- Without the macro: ports absent, CC/CD read 8'h00, writes to CC/CD ignored.

Test Plan:
1. RST, then ADDR=5A, 5A, A5 on consecutive CLKs -> LOCKED falls the cycle after A5. SO then emits 0,0,0,0,0,0,1,0,1,0,0,0,1,0,1,0,0,0, then stays 1.
2. While locked, I/O write C2=0x33, then unlock, then read C2 -> DQ_O=0xFF. Write C2=0x33 after unlock -> read 0x33; segment 2 memory cycle -> ROMCEn=0, RADDR=0x33.
3. LAO=0xAB, LAOH=0, RADDR_W=8, memory cycle on segment 5 -> RADDR=0xB5, ROMCEn=0, RAMCEn=1.
4. CF=0x02 (WP set); memory cycle on segment 1 with OEn=0 -> RAMCEn=0. With WEn=0 -> RAMCEn=1. Read CF -> 0x02.
5. Write CF=0x01 -> LOCKED=1 next cycle, DQ_OE stays 0, C2 contents retained after re-unlock. RST mid-shift -> SO=1 immediately after the reset edge.
6. (BANDAI_GPIO_EN) CC=0x3, CD=0x5, IO_I=0xC -> IO_OE=0x3, IO_O=0x5. Read CD returns 0xD two CLKs after IO_I settles.

Source files
------------

// File: rtl/bandai2003_mapper_gen2.sv
// Bandai 2003 cartridge mapper, gen2: unlock FSM, boot shifter, banks, decode.
// Define BANDAI_GPIO_EN to add the 4-bit GPIO block on ports CC/CD.
module bandai2003_mapper_gen2 #(
    parameter int                RADDR_W = 8,
    parameter int                SO_LEN  = 18,
    parameter logic [SO_LEN-1:0] SO_PAT  = 18'h05140,
    parameter logic [7:0]        KEY0    = 8'h5A,
    parameter logic [7:0]        KEY1    = 8'hA5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CEn,
    input  logic               WEn,
    input  logic               OEn,
    input  logic               SSn,
    input  logic [7:0]         ADDR,
    input  logic [7:0]         DQ_I,
    output logic [7:0]         DQ_O,
    output logic               DQ_OE,
    output logic               SO,
    output logic               LOCKED,
    output logic               ROMCEn,
    output logic               RAMCEn,
`ifdef BANDAI_GPIO_EN
    input  logic [3:0]         IO_I,
    output logic [3:0]         IO_O,
    output logic [3:0]         IO_OE,
`endif
    output logic [RADDR_W-1:0] RADDR
);

    typedef enum logic [1:0] {S_K0, S_K1, S_UNL} state_t;

    state_t            state_q, state_d;
    logic [SO_LEN-1:0] sh_q;
    logic [7:0]        lao_q, ramb_q, romb0_q, romb1_q;
    logic [3:0]        laoh_q;
    logic              wp_q;
    logic              we_q, io_q;
    logic [7:0]        addr_q, dat_q;
    logic              locked, io, commit, relock, mce, oe;
    logic [3:0]        seg;
    logic [7:0]        rd_data;

    assign locked = (state_q != S_UNL);
    assign io     = ~SSn | ~CEn;
    // Commit on the sampled rising edge of WEn, from the latched cycle.
    assign commit = WEn & ~we_q & io_q & ~locked;
    assign relock = commit & (addr_q == 8'hCF) & dat_q[0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_K0:    if (ADDR == KEY0) state_d = S_K1;
            S_K1:    if (ADDR == KEY1) state_d = S_UNL;
            S_UNL:   if (relock) state_d = S_K0;
            default: state_d = S_K0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_K0;
            sh_q    <= '1;
        end else begin
            state_q <= state_d;
            if (state_q == S_K1 && state_d == S_UNL) sh_q <= SO_PAT;
            else sh_q <= {1'b1, sh_q[SO_LEN-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q    <= 1'b1;
            io_q    <= 1'b0;
            addr_q  <= 8'h00;
            dat_q   <= 8'h00;
            lao_q   <= 8'hFF;
            ramb_q  <= 8'hFF;
            romb0_q <= 8'hFF;
            romb1_q <= 8'hFF;
            laoh_q  <= 4'h0;
            wp_q    <= 1'b0;
        end else begin
            we_q <= WEn;
            if (!WEn) begin
                addr_q <= ADDR;
                dat_q  <= DQ_I;
                io_q   <= io;
            end
            if (commit) begin
                case (addr_q)
                    8'hC0:   lao_q   <= dat_q;
                    8'hC1:   ramb_q  <= dat_q;
                    8'hC2:   romb0_q <= dat_q;
                    8'hC3:   romb1_q <= dat_q;
                    8'hCE:   laoh_q  <= dat_q[3:0];
                    8'hCF:   wp_q    <= dat_q[1];
                    default: ;
                endcase
            end
        end
    end

`ifdef BANDAI_GPIO_EN
    logic [3:0] ioctl_q, iolat_q, sync1_q, sync2_q;
    logic [3:0] gpio_rd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ioctl_q <= 4'h0;
            iolat_q <= 4'h0;
            sync1_q <= 4'h0;
            sync2_q <= 4'h0;
        end else begin
            sync1_q <= IO_I;
            sync2_q <= sync1_q;
            if (commit && addr_q == 8'hCC) ioctl_q <= dat_q[3:0];
            if (commit && addr_q == 8'hCD) iolat_q <= dat_q[3:0];
        end
    end

    assign IO_OE   = ioctl_q;
    assign IO_O    = iolat_q;
    assign gpio_rd = (ioctl_q & iolat_q) | (~ioctl_q & sync2_q);
`endif

    always_comb begin
        rd_data = 8'h00;
        case (ADDR)
            8'hC0:   rd_data = lao_q;
            8'hC1:   rd_data = ramb_q;
            8'hC2:   rd_data = romb0_q;
            8'hC3:   rd_data = romb1_q;
            8'hCE:   rd_data = {4'h0, laoh_q};
            8'hCF:   rd_data = {6'b0, wp_q, 1'b0};
`ifdef BANDAI_GPIO_EN
            8'hCC:   rd_data = {4'h0, ioctl_q};
            8'hCD:   rd_data = {4'h0, gpio_rd};
`endif
            default: rd_data = 8'h00;
        endcase
    end

    assign oe     = ~locked & io & ~OEn & WEn;
    assign DQ_OE  = oe;
    assign DQ_O   = oe ? rd_data : 8'h00;
    assign SO     = sh_q[0];
    assign LOCKED = locked;

    assign mce = ~locked & SSn & ~CEn;
    assign seg = ADDR[7:4];

    always_comb begin
        ROMCEn = 1'b1;
        RAMCEn = 1'b1;
        RADDR  = '0;
        if (mce) begin
            if (seg == 4'd1) begin
                if (!(wp_q && !WEn)) begin
                    RAMCEn = 1'b0;
                    RADDR  = RADDR_W'(ramb_q);
                end
            end else if (seg == 4'd2) begin
                ROMCEn = 1'b0;
                RADDR  = RADDR_W'(romb0_q);
            end else if (seg == 4'd3) begin
                ROMCEn = 1'b0;
                RADDR  = RADDR_W'(romb1_q);
            end else if (seg != 4'd0) begin
                // Low RADDR_W bits of {LAOH, LAO, segment}.
                ROMCEn = 1'b0;
                RADDR  = RADDR_W'({laoh_q, lao_q, seg});
            end
        end
    end

endmodule
